cpu_loader: RTL and testbench

// - Host-side program loader sitting directly upstream of the A-RISC cpu.
// - Consumes a byte stream (UART RX side, valid/ready) and writes instructions into IRAM and data into DRAM.
// - Pulses cpu start, waits for cpu idle, then can stream DRAM contents back out (TX side, valid/ready).
// - While not running the cpu, owns both RAM ports via host_sel (top-level mux: 1 = loader, 0 = cpu).

---
 rtl/loader_pkg.sv | 36 +++
 rtl/cpu_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_cpu_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the cpu_loader host-side program loader:
//   - command byte encodings accepted on the RX stream
//   - the acknowledge byte returned on TX when a RUN completes
//   - the loader FSM state enumeration
//   - a helper that tells whether a command byte is followed by a length byte
// ---------------------------------------------------------------------------
package loader_pkg;

    localparam logic [7:0] C_LDI   = 8'h01;
    localparam logic [7:0] C_LDD   = 8'h02;
    localparam logic [7:0] C_RUN   = 8'h03;
    localparam logic [7:0] C_DMP   = 8'h04;
    localparam logic [7:0] RUN_ACK = 8'h03;

    typedef enum logic [3:0] {
        S_CMD,
        S_LEN,
        S_ILO,
        S_IHI,
        S_DDAT,
        S_RUN_GO,
        S_RUN_ARM,
        S_RUN_WAIT,
        S_DRD,
        S_DWT,
        S_TX
    } state_t;

    // LDI, LDD and DMP all carry a length byte after the command byte.
    function automatic logic cmd_has_len(input logic [7:0] cmd);
        return (cmd == C_LDI) || (cmd == C_LDD) || (cmd == C_DMP);
    endfunction

endpackage

// File: rtl/cpu_loader.sv
// ---------------------------------------------------------------------------
// cpu_loader
// Host-side program loader in front of the A-RISC cpu. Parses a byte command
// stream, fills IRAM (16-bit words, lo byte first) and DRAM (bytes), starts
// the cpu and waits for it to go idle, and streams DRAM back out on TX.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rx_data/rx_valid/rx_ready  command + payload byte stream in
//   tx_data/tx_valid/tx_ready  response byte stream out
//   iram_we/iram_addr/iram_din IRAM write port
//   dram_we/dram_addr/dram_din DRAM write port (dram_addr also used for reads)
//   dram_dout                DRAM read data, one cycle after address
//   cpu_start                one-cycle start pulse to the cpu
//   cpu_idle                 cpu idle flag
//   host_sel                 1 = loader owns the RAM ports, 0 = cpu does
//   err                      sticky unknown-command flag
// ---------------------------------------------------------------------------
module cpu_loader
    import loader_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          iram_we,
    output logic [AW-1:0] iram_addr,
    output logic [15:0]   iram_din,
    output logic          dram_we,
    output logic [AW-1:0] dram_addr,
    output logic [7:0]    dram_din,
    input  logic [7:0]    dram_dout,
    output logic          cpu_start,
    input  logic          cpu_idle,
    output logic          host_sel,
    output logic          err
);

    state_t          state_reg, state_next;
    logic [7:0]      cmd_reg;
    logic [7:0]      lo_reg;
    logic [AW:0]     rem_reg;     // items still to transfer in this command
    logic [AW-1:0]   addr_reg;    // per-command address, wraps mod 2^AW
    logic [7:0]      tx_data_reg;
    logic            iram_we_reg;
    logic [AW-1:0]   iram_addr_reg;
    logic [15:0]     iram_din_reg;
    logic            dram_we_reg;
    logic [AW-1:0]   dram_addr_reg;
    logic [7:0]      dram_din_reg;
    logic            err_reg;

    logic            rx_hs;
    logic            last_item;
    logic [AW:0]     len_decoded;

    assign rx_hs     = rx_valid & rx_ready;
    assign last_item = (rem_reg == (AW+1)'(1));
    // A length byte of zero stands for 256 items.
    assign len_decoded = (rx_data == 8'h00) ? (AW+1)'(256) : (AW+1)'(rx_data);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_CMD;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_CMD: begin
                if (rx_hs) begin
                    if (cmd_has_len(rx_data)) begin
                        state_next = S_LEN;
                    end else if (rx_data == C_RUN) begin
                        state_next = S_RUN_GO;
                    end
                end
            end
            S_LEN: begin
                if (rx_hs) begin
                    if (cmd_reg == C_LDI) begin
                        state_next = S_ILO;
                    end else if (cmd_reg == C_LDD) begin
                        state_next = S_DDAT;
                    end else begin
                        state_next = S_DRD;
                    end
                end
            end
            S_ILO:      if (rx_hs) state_next = S_IHI;
            S_IHI:      if (rx_hs) state_next = last_item ? S_CMD : S_ILO;
            S_DDAT:     if (rx_hs && last_item) state_next = S_CMD;
            S_RUN_GO:   state_next = S_RUN_ARM;
            // The cpu may still report idle here before it has seen the
            // start pulse, so this cycle deliberately ignores cpu_idle.
            S_RUN_ARM:  state_next = S_RUN_WAIT;
            S_RUN_WAIT: if (cpu_idle) state_next = S_TX;
            S_DRD:      state_next = S_DWT;
            S_DWT:      state_next = S_TX;
            S_TX:       if (tx_ready) state_next = last_item ? S_CMD : S_DRD;
            default:    state_next = S_CMD;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        rx_ready  = 1'b0;
        tx_valid  = 1'b0;
        cpu_start = 1'b0;
        host_sel  = 1'b1;
        case (state_reg)
            S_CMD, S_LEN, S_ILO, S_IHI, S_DDAT: rx_ready = 1'b1;
            S_RUN_GO: begin
                cpu_start = 1'b1;
                host_sel  = 1'b0;
            end
            S_RUN_ARM, S_RUN_WAIT: host_sel = 1'b0;
            S_TX: tx_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: counters, latched bytes, RAM write/read port registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_reg       <= 8'h00;
            lo_reg        <= 8'h00;
            rem_reg       <= '0;
            addr_reg      <= '0;
            tx_data_reg   <= 8'h00;
            iram_we_reg   <= 1'b0;
            iram_addr_reg <= '0;
            iram_din_reg  <= 16'h0000;
            dram_we_reg   <= 1'b0;
            dram_addr_reg <= '0;
            dram_din_reg  <= 8'h00;
            err_reg       <= 1'b0;
        end else begin
            iram_we_reg <= 1'b0;
            dram_we_reg <= 1'b0;
            case (state_reg)
                S_CMD: begin
                    if (rx_hs) begin
                        cmd_reg <= rx_data;
                        if (!cmd_has_len(rx_data) && rx_data != C_RUN) begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                S_LEN: begin
                    if (rx_hs) begin
                        rem_reg  <= len_decoded;
                        addr_reg <= '0;
                        // A dump reads address 0 in the very next state.
                        if (cmd_reg == C_DMP) begin
                            dram_addr_reg <= '0;
                        end
                    end
                end
                S_ILO: begin
                    if (rx_hs) begin
                        lo_reg <= rx_data;
                    end
                end
                S_IHI: begin
                    if (rx_hs) begin
                        iram_we_reg   <= 1'b1;
                        iram_addr_reg <= addr_reg;
                        iram_din_reg  <= {rx_data, lo_reg};
                        addr_reg      <= addr_reg + AW'(1);
                        rem_reg       <= rem_reg - (AW+1)'(1);
                    end
                end
                S_DDAT: begin
                    if (rx_hs) begin
                        dram_we_reg   <= 1'b1;
                        dram_addr_reg <= addr_reg;
                        dram_din_reg  <= rx_data;
                        addr_reg      <= addr_reg + AW'(1);
                        rem_reg       <= rem_reg - (AW+1)'(1);
                    end
                end
                S_RUN_WAIT: begin
                    if (cpu_idle) begin
                        tx_data_reg <= RUN_ACK;
                        // The acknowledge is a one-item transfer so S_TX
                        // returns to S_CMD after it.
                        rem_reg     <= (AW+1)'(1);
                    end
                end
                S_DWT: tx_data_reg <= dram_dout;
                S_TX: begin
                    if (tx_ready) begin
                        addr_reg      <= addr_reg + AW'(1);
                        dram_addr_reg <= addr_reg + AW'(1);
                        rem_reg       <= rem_reg - (AW+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data   = tx_data_reg;
    assign iram_we   = iram_we_reg;
    assign iram_addr = iram_addr_reg;
    assign iram_din  = iram_din_reg;
    assign dram_we   = dram_we_reg;
    assign dram_addr = dram_addr_reg;
    assign dram_din  = dram_din_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_cpu_loader.sv
// ---------------------------------------------------------------------------
// tb_cpu_loader
// Self-checking bench for cpu_loader. Surrounds the DUT with a synchronous
// IRAM/DRAM pair and a cpu model that stays busy for 5 cycles after a start
// pulse. Expected RAM contents and TX bytes come from a reference image of
// what each command should leave behind.
// ---------------------------------------------------------------------------
module tb_cpu_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic          iram_we;
    logic [AW-1:0] iram_addr;
    logic [15:0]   iram_din;
    logic          dram_we;
    logic [AW-1:0] dram_addr;
    logic [7:0]    dram_din;
    logic [7:0]    dram_dout = 8'h00;
    logic          cpu_start;
    logic          cpu_idle;
    logic          host_sel;
    logic          err;

    always #5 clk = ~clk;

    cpu_loader #(.AW(AW)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .iram_we(iram_we), .iram_addr(iram_addr), .iram_din(iram_din),
        .dram_we(dram_we), .dram_addr(dram_addr), .dram_din(dram_din),
        .dram_dout(dram_dout),
        .cpu_start(cpu_start), .cpu_idle(cpu_idle),
        .host_sel(host_sel), .err(err)
    );

    // Environment: RAMs and cpu
    logic [15:0] iram_mem [256];
    logic [7:0]  dram_mem [256];
    int          busy_cnt = 0;

    always @(posedge clk) begin
        if (iram_we) iram_mem[iram_addr] <= iram_din;
        if (dram_we) dram_mem[dram_addr] <= dram_din;
        dram_dout <= dram_mem[dram_addr];
    end

    always @(posedge clk) begin
        if (cpu_start)         busy_cnt <= 5;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign cpu_idle = (busy_cnt == 0);

    // Reference image
    logic [15:0] iram_ref [256];
    logic [7:0]  dram_ref [256];

    // Bookkeeping
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor + tx_ready driver (negedge, away from the active edge)
    logic [7:0] tx_got [$];
    int  iram_cnt = 0, dram_cnt = 0, start_cnt = 0, hs_low_cnt = 0;
    int  we_bad = 0, stable_bad = 0, busy_bad = 0;
    int  stall_left = 0;
    int  stall_after = 1;
    bit  prev_stall = 0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (stall_left > 0 && tx_valid && tx_got.size() == stall_after) begin
            tx_ready = 1'b0;
            stall_left--;
        end else begin
            tx_ready = 1'b1;
        end
        if (!rst) begin
            if (prev_stall && (!tx_valid || tx_data != prev_data)) stable_bad++;
            if (tx_valid && tx_ready) tx_got.push_back(tx_data);
            if (iram_we) iram_cnt++;
            if (dram_we) dram_cnt++;
            if (cpu_start) start_cnt++;
            if (!host_sel) hs_low_cnt++;
            if (!host_sel && (iram_we || dram_we)) we_bad++;
            if (!cpu_idle && host_sel) busy_bad++;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
    end

    // Stimulus helpers
    bit gap_en = 0;

    task automatic send_byte(input logic [7:0] b);
        int t;
        while (gap_en && $urandom_range(0, 2) == 0) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (!rx_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("rx_timeout", 1, 0);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(1);
    endtask

    logic [15:0] wbuf [256];
    logic [7:0]  bbuf [256];

    task automatic ldi(input int n);
        int cnt;
        cnt = (n == 0) ? 256 : n;
        send_byte(8'h01);
        send_byte(8'(n));
        for (int i = 0; i < cnt; i++) begin
            send_byte(wbuf[i][7:0]);
            send_byte(wbuf[i][15:8]);
            iram_ref[i] = wbuf[i];
        end
        idle_cycles(3);
        $display("txn LDI n=%0d", cnt);
    endtask

    task automatic ldd(input int n);
        int cnt;
        cnt = (n == 0) ? 256 : n;
        send_byte(8'h02);
        send_byte(8'(n));
        for (int i = 0; i < cnt; i++) begin
            send_byte(bbuf[i]);
            dram_ref[i] = bbuf[i];
        end
        idle_cycles(3);
        $display("txn LDD n=%0d", cnt);
    endtask

    task automatic check_iram(input string tag, input int cnt);
        int bad = 0;
        for (int i = 0; i < cnt; i++) if (iram_mem[i] !== iram_ref[i]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic check_dram(input string tag, input int cnt);
        int bad = 0;
        for (int i = 0; i < cnt; i++) if (dram_mem[i] !== dram_ref[i]) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic dmp(input string tag, input int n);
        int cnt, t, bad;
        cnt = (n == 0) ? 256 : n;
        tx_got.delete();
        send_byte(8'h04);
        send_byte(8'(n));
        t = 0;
        while (tx_got.size() < cnt && t < 20 * cnt + 100) begin
            @(negedge clk);
            t++;
        end
        idle_cycles(4);
        chk({tag, "_count"}, tx_got.size(), cnt);
        bad = 0;
        for (int i = 0; i < cnt && i < tx_got.size(); i++)
            if (tx_got[i] !== dram_ref[i]) bad++;
        chk({tag, "_data"}, bad, 0);
        $display("txn DMP n=%0d received=%0d", cnt, tx_got.size());
    endtask

    initial begin
        int ic, dc, sc, hc, t, n;

        // Reset state
        do_reset();
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_iram_we", iram_we, 0);
        chk("rst_dram_we", dram_we, 0);
        chk("rst_iram_addr", iram_addr, 0);
        chk("rst_dram_addr", dram_addr, 0);
        chk("rst_iram_din", iram_din, 0);
        chk("rst_cpu_start", cpu_start, 0);
        chk("rst_host_sel", host_sel, 1);
        chk("rst_err", err, 0);

        // LDI N=2: 01,02,34,12,05,00
        ic = iram_cnt;
        wbuf[0] = 16'h1234;
        wbuf[1] = 16'h0005;
        ldi(2);
        chk("ldi2_we_count", iram_cnt - ic, 2);
        chk("ldi2_word0", iram_mem[0], 16'h1234);
        chk("ldi2_word1", iram_mem[1], 16'h0005);
        chk("ldi2_back_in_cmd", rx_ready, 1);

        // Random LDI with rx_valid gaps
        gap_en = 1;
        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom);
            ic = iram_cnt;
            ldi(n);
            chk("ldi_rand_we_count", iram_cnt - ic, n);
            check_iram("ldi_rand_contents", n);
        end

        // LDD N=0 -> 256 bytes 0..255
        for (int i = 0; i < 256; i++) bbuf[i] = 8'(i);
        dc = dram_cnt;
        ldd(0);
        chk("ldd256_we_count", dram_cnt - dc, 256);
        check_dram("ldd256_contents", 256);
        chk("ldd256_last_addr", dram_addr, 8'hFF);

        // LDD AA,BB,CC then DMP 3 with a 4-cycle stall on the 2nd byte
        gap_en = 0;
        bbuf[0] = 8'hAA; bbuf[1] = 8'hBB; bbuf[2] = 8'hCC;
        ldd(3);
        stall_after = 1;
        stall_left  = 4;
        dmp("dmp3", 3);
        chk("dmp3_stall_used", stall_left, 0);
        chk("dmp3_tx_stable", stable_bad, 0);
        chk("dmp3_tx_idle_after", tx_valid, 0);

        // Random LDD/DMP rounds, random tx_ready stall positions
        gap_en = 1;
        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) bbuf[i] = 8'($urandom);
            ldd(n);
            check_dram("ldd_rand_contents", 256);
            stall_after = $urandom_range(0, 3);
            stall_left  = $urandom_range(0, 5);
            dmp("dmp_rand", $urandom_range(1, 60));
        end
        stall_left = 0;
        dmp("dmp256", 0);
        chk("dmp_tx_stable_all", stable_bad, 0);

        // RUN: the cpu model is busy for 5 cycles after the start edge, so
        // host_sel is low for S_RUN_GO + 5 busy cycles + the cycle that sees idle.
        for (int k = 0; k < 2; k++) begin
            sc = start_cnt;
            hc = hs_low_cnt;
            tx_got.delete();
            send_byte(8'h03);
            t = 0;
            while (tx_got.size() < 1 && t < 100) begin
                @(negedge clk);
                t++;
            end
            idle_cycles(10);
            chk("run_start_pulses", start_cnt - sc, 1);
            chk("run_host_sel_low", hs_low_cnt - hc, 7);
            chk("run_ack_count", tx_got.size(), 1);
            if (tx_got.size() > 0) chk("run_ack_byte", tx_got[0], 8'h03);
            chk("run_host_sel_back", host_sel, 1);
            $display("txn RUN ack_bytes=%0d", tx_got.size());
        end
        chk("run_no_we_while_cpu_owns", we_bad, 0);
        chk("run_cpu_busy_while_loader_owns", busy_bad, 0);

        // Unknown command
        ic = iram_cnt;
        dc = dram_cnt;
        send_byte(8'h7F);
        idle_cycles(3);
        $display("txn BAD cmd=7f");
        chk("bad_err_set", err, 1);
        chk("bad_no_iram_we", iram_cnt - ic, 0);
        chk("bad_no_dram_we", dram_cnt - dc, 0);
        chk("bad_rx_ready", rx_ready, 1);
        bbuf[0] = 8'h66;
        ldd(1);
        chk("bad_then_ldd_we", dram_cnt - dc, 1);
        chk("bad_then_ldd_data", dram_mem[0], 8'h66);
        chk("bad_err_sticky", err, 1);

        // Reset after the lo byte of an LDI word
        gap_en = 0;
        ic = iram_cnt;
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h77);
        do_reset();
        $display("txn RST mid-LDI");
        chk("rstmid_no_iram_we", iram_cnt - ic, 0);
        chk("rstmid_err_cleared", err, 0);
        chk("rstmid_rx_ready", rx_ready, 1);
        wbuf[0] = 16'hBEEF;
        ldi(1);
        chk("rstmid_fresh_ldi_we", iram_cnt - ic, 1);
        chk("rstmid_fresh_ldi_word", iram_mem[0], 16'hBEEF);
        chk("rstmid_addr0", iram_addr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
